// File: rtl/alu_arbiter_if.sv
// Bundled request/response/ALU-side signals for alu_arbiter.
// slave = arbiter side, master = requesters plus the ALU instance.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6
);
  logic              req0_valid;
  logic              req0_ready;
  logic [FUNC_W-1:0] req0_func;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [FUNC_W-1:0] req1_func;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_branch;

  logic [FUNC_W-1:0] alu_func_out;
  logic [DATA_W-1:0] alu_a_out;
  logic [DATA_W-1:0] alu_b_out;
  logic [DATA_W-1:0] alu_o_in;
  logic              alu_branch_in;

  logic              busy;

  modport slave (
    input  req0_valid, req0_func, req0_a, req0_b,
    input  req1_valid, req1_func, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_o_in, alu_branch_in,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_branch, alu_func_out, alu_a_out, alu_b_out, busy
  );

  modport master (
    output req0_valid, req0_func, req0_a, req0_b,
    output req1_valid, req1_func, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_o_in, alu_branch_in,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_branch, alu_func_out, alu_a_out, alu_b_out, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU (IDLE->EXEC->RESP).
// Optional macro ALU_ARB_RR_EN: round-robin grant instead of fixed req0 priority.
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int FUNC_W  = 6,
  parameter int ALU_LAT = 1
) (
  input logic          ref_clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [FUNC_W-1:0] r_func;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_branch;
  logic              r_owner;
  logic [3:0]        r_cnt;

  logic w_grant0;
  logic w_grant1;
  logic w_rdy0;
  logic w_rdy1;
  logic w_accept;
  logic w_last;
  logic w_rsp_take;

`ifdef ALU_ARB_RR_EN
  logic r_last_grant;

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  end
`else
  always_comb begin
    w_grant0 = bus.req0_valid;
    w_grant1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  assign w_rdy0     = (r_state == IDLE) && reset && w_grant0;
  assign w_rdy1     = (r_state == IDLE) && reset && w_grant1;
  assign w_accept   = w_rdy0 | w_rdy1;
  assign w_last     = (r_cnt == LAT_LAST);
  assign w_rsp_take = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge ref_clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_next = EXEC;
      EXEC:    if (w_last)     w_next = RESP;
      RESP:    if (w_rsp_take) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_cnt is zero-based: EXEC cycle k of ALU_LAT sees r_cnt == k-1.
  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      r_func       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_result <= '0;
      r_rsp_branch <= 1'b0;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
`ifdef ALU_ARB_RR_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_func  <= w_rdy1 ? bus.req1_func : bus.req0_func;
            r_a     <= w_rdy1 ? bus.req1_a    : bus.req0_a;
            r_b     <= w_rdy1 ? bus.req1_b    : bus.req0_b;
            r_owner <= w_rdy1;
            r_cnt   <= '0;
`ifdef ALU_ARB_RR_EN
            r_last_grant <= w_rdy1;
`endif
          end
        end
        EXEC: begin
          if (w_last) begin
            r_rsp_result <= bus.alu_o_in;
            r_rsp_branch <= bus.alu_branch_in;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req0_ready   = 1'b0;
    bus.req1_ready   = 1'b0;
    bus.rsp0_valid   = 1'b0;
    bus.rsp1_valid   = 1'b0;
    bus.alu_func_out = '0;
    bus.alu_a_out    = '0;
    bus.alu_b_out    = '0;
    bus.rsp_result   = r_rsp_result;
    bus.rsp_branch   = r_rsp_branch;
    bus.busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        bus.req0_ready = w_rdy0;
        bus.req1_ready = w_rdy1;
      end
      EXEC: begin
        bus.alu_func_out = r_func;
        bus.alu_a_out    = r_a;
        bus.alu_b_out    = r_b;
      end
      RESP: begin
        bus.rsp0_valid = ~r_owner;
        bus.rsp1_valid = r_owner;
      end
      default: ;
    endcase
  end

endmodule
